reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Round-robin arbiter that shares one register8 instance (8-bit, ld/din/dout) between NREQ independent writers.
- Sequences the register's ld/din and returns the loaded value to the winning requester with a one-cycle grant pulse.
- Sits directly in front of register8. Its reg_ld/reg_din drive the register's ld/din, and the register's dout feeds back into reg_dout.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data width; must match the register's din/dout width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset. Asserted (0) immediately forces every flop to its reset value. Deassertion is synchronous to clk.
- req  in  NREQ  per-requester write request, level. Held until the matching gnt bit is seen.
- wdata  in  NREQ*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH]. Must stay stable while req[i]=1.
- gnt  out  NREQ  one-hot, one-cycle pulse. Marks completion of requester i's write.
- rdata  out  WIDTH  value read back from the register after the granted write; valid while gnt≠0 and held until the next grant.
- busy  out  1  high while a write transaction is in progress (state≠IDLE).
- reg_ld  out  1  load strobe to the shared register.
- reg_din  out  WIDTH  data to the shared register.
- reg_dout  in  WIDTH  current register contents.

Behaviour:
- Reset values:
  - state=IDLE, ptr=0, win=0.
  - gnt=0, rdata=0, busy=0, reg_ld=0, reg_din=0.
- FSM states: IDLE, LOAD, ACK. All outputs are registered.
- IDLE:
  - If req=0, stay in IDLE; reg_ld=0.
  - Otherwise pick the winner: the first set req bit scanning ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
  - Latch win, set reg_din<=wdata[win], reg_ld<=1, busy<=1, go to LOAD.
- LOAD:
  - reg_ld is high for exactly this one cycle; the register captures reg_din on the edge leaving LOAD.
  - Next: reg_ld<=0, go to ACK.
- ACK:
  - The register now holds the new value.
  - gnt[win]<=1 and rdata<=reg_dout; these are visible in the cycle after ACK.
  - ptr<=(win+1) mod NREQ, busy<=0, go to IDLE.
- gnt is high for the single cycle that follows ACK, which is the IDLE cycle. gnt clears on the next edge unconditionally.
- Handshake and throughput:
  - A requester samples gnt and drops req at the next edge.
  - Arbitration uses req as seen in that IDLE cycle. A requester that keeps req high after its gnt is treated as issuing a new request.
  - Fairness comes from the rotated ptr.
  - Peak throughput is one write per 3 cycles; with back-to-back requesters, IDLE lasts one cycle.
- Request changes mid-transaction:
  - Changes to req or wdata during LOAD/ACK are ignored; the transaction in flight always completes and grants.
  - No abort path. If req[win] is dropped before gnt, the write and gnt still happen.
- Simultaneous requests: exactly one winner per arbitration. Losers keep req high and are served in later rounds in rotation order.
- ptr wrap: NREQ-1 → 0.
- Reset asserted mid-LOAD or mid-ACK:
  - Immediate return to reset values; no gnt is issued.
  - If reg_ld was high it drops at once, so the write may or may not have landed.
  - The register's own reset is driven externally and is not this block's concern.
- reg_din holds its last value outside LOAD (no toggling when idle).

Decomposition:
- Package reg_arb_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_LOAD=2'd1, ST_ACK=2'd2.
  - Default NREQ/WIDTH constants.
- One sub-module: rr_pick (parameter NREQ).
  - Inputs req and ptr; outputs any and win index.
  - Pure combinational rotate, priority-find and un-rotate, so it can be reused by other arbiters in the design.

Test Plan:
- Reset: hold reset=0 for 2 cycles with req=4'b1111.
  - Required: gnt=0, reg_ld=0, reg_din=0, rdata=0, busy=0 throughout.
  - After release, the first grant goes to req0.
- Single writer: req=4'b0100, wdata[2]=8'h55.
  - Required: reg_ld high for exactly 1 cycle with reg_din=8'h55.
  - Two cycles after reg_ld rises, gnt=4'b0100 and rdata=8'h55; busy high for the LOAD and ACK cycles.
- Contention and fairness: all four requesting with data 8'h00/8'h01/8'hFF/8'hAA, each dropping req after its gnt.
  - Required: grant order 0,1,2,3; rdata sequence 00,01,FF,AA; writes spaced 3 cycles apart.
- Rotation wrap: ptr=3 after serving req2, then req=4'b1001.
  - Required: req3 is granted before req0.
- Mid-transaction change: change wdata[1] from 8'hBA to 8'h0B and drop req1 during LOAD.
  - Required: register ends at 8'hBA, gnt[1] still pulses, rdata=8'hBA.
- Reset mid-ACK: assert reset during ACK.
  - Required: no gnt pulse, busy=0 immediately, ptr=0 after release.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the register write arbiter.
package reg_arb_pkg;

    localparam int unsigned DEF_NREQ  = 4;
    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate req by ptr, find first set bit, map back.
module rr_pick #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic             any_o,
    output logic [PTR_W-1:0] win_o
);

    logic [NREQ-1:0]  rot;
    logic [PTR_W:0]   idx;
    logic [PTR_W-1:0] off;
    logic [PTR_W:0]   sum;

    // rot[i] is the request that sits i positions after ptr
    always_comb begin
        rot = '0;
        idx = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            idx = {1'b0, ptr_i} + (PTR_W+1)'(i);
            if (idx >= (PTR_W+1)'(NREQ)) begin
                idx = idx - (PTR_W+1)'(NREQ);
            end
            rot[i] = req_i[idx[PTR_W-1:0]];
        end
    end

    always_comb begin
        off = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = PTR_W'(i);
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= (PTR_W+1)'(NREQ)) begin
            sum = sum - (PTR_W+1)'(NREQ);
        end
        any_o = |req_i;
        win_o = sum[PTR_W-1:0];
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin sharing of one load/din/dout register among NREQ writers,
// returning the read-back value with a one-cycle grant pulse.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      rdata,
    output logic                  busy,
    output logic                  reg_ld,
    output logic [WIDTH-1:0]      reg_din,
    input  logic [WIDTH-1:0]      reg_dout
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win_q, win_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             busy_q, busy_d;
    logic             reg_ld_q, reg_ld_d;
    logic [WIDTH-1:0] reg_din_q, reg_din_d;

    logic             pick_any;
    logic [PTR_W-1:0] pick_win;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .any_o (pick_any),
        .win_o (pick_win)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            gnt_q     <= '0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            reg_ld_q  <= 1'b0;
            reg_din_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            gnt_q     <= gnt_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            reg_ld_q  <= reg_ld_d;
            reg_din_q <= reg_din_d;
        end
    end

    // gnt defaults to zero so every pulse lasts exactly one cycle
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        gnt_d     = '0;
        rdata_d   = rdata_q;
        busy_d    = busy_q;
        reg_ld_d  = 1'b0;
        reg_din_d = reg_din_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    win_d     = pick_win;
                    reg_din_d = wdata[pick_win*WIDTH +: WIDTH];
                    reg_ld_d  = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_ACK;
            end
            ST_ACK: begin
                gnt_d[win_q] = 1'b1;
                rdata_d      = reg_dout;
                ptr_d        = (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + PTR_W'(1);
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign gnt     = gnt_q;
    assign rdata   = rdata_q;
    assign busy    = busy_q;
    assign reg_ld  = reg_ld_q;
    assign reg_din = reg_din_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter with a behavioural shared register.
module tb_reg_write_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;

    typedef struct {
        logic [NREQ-1:0]  gnt;
        logic [WIDTH-1:0] rdata;
        int               gap;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      rdata;
    logic                  busy;
    logic                  reg_ld;
    logic [WIDTH-1:0]      reg_din;
    logic [WIDTH-1:0]      reg_dout;
    logic [WIDTH-1:0]      reg_q = '0;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    int   last_gnt_cyc = 0;

    reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .wdata    (wdata),
        .gnt      (gnt),
        .rdata    (rdata),
        .busy     (busy),
        .reg_ld   (reg_ld),
        .reg_din  (reg_din),
        .reg_dout (reg_dout)
    );

    always #5 clk = ~clk;

    // the shared register8
    always @(posedge clk) if (reg_ld) reg_q <= reg_din;
    assign reg_dout = reg_q;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // requesters drop their req once they see their grant
    always @(negedge clk) req = req & ~gnt;

    // monitor: compare every grant against the scoreboard
    always @(negedge clk) begin
        if (reset && gnt != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_gnt", 32'(gnt), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("gnt", 32'(gnt), 32'(e.gnt));
                chk("rdata", 32'(rdata), 32'(e.rdata));
                if (e.gap != 0) chk("gnt_spacing", 32'(cyc - last_gnt_cyc), 32'(e.gap));
            end
            last_gnt_cyc = cyc;
        end
    end

    task automatic push(input logic [NREQ-1:0] g, input logic [WIDTH-1:0] d, input int gap);
        exp_t e;
        e.gnt = g; e.rdata = d; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!(req == '0 && !busy && gnt == '0 && exp_q.size() == 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, 32'(n < 60), 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        req   = '0;
        wdata = '0;

        // reset held with all requesting, data 00/01/FF/AA
        @(negedge clk);
        req = 4'b1111;
        wdata[0*8 +: 8] = 8'h00;
        wdata[1*8 +: 8] = 8'h01;
        wdata[2*8 +: 8] = 8'hFF;
        wdata[3*8 +: 8] = 8'hAA;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_reg_ld", 32'(reg_ld), 32'd0);
            chk("rst_reg_din", 32'(reg_din), 32'd0);
            chk("rst_rdata", 32'(rdata), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        push(4'b0001, 8'h00, 0);
        push(4'b0010, 8'h01, 3);
        push(4'b0100, 8'hFF, 3);
        push(4'b1000, 8'hAA, 3);
        reset = 1'b1;
        wait_done("contention");

        // single writer
        wdata[2*8 +: 8] = 8'h55;
        req = 4'b0100;
        push(4'b0100, 8'h55, 0);
        @(negedge clk);
        chk("single_ld_hi", 32'(reg_ld), 32'd1);
        chk("single_din", 32'(reg_din), 32'h55);
        chk("single_busy_load", 32'(busy), 32'd1);
        @(negedge clk);
        chk("single_ld_lo", 32'(reg_ld), 32'd0);
        chk("single_busy_ack", 32'(busy), 32'd1);
        @(negedge clk);
        chk("single_busy_gnt", 32'(busy), 32'd0);
        wait_done("single");

        // ptr now 3: req3 must beat req0
        wdata[0*8 +: 8] = 8'h3C;
        wdata[3*8 +: 8] = 8'hC3;
        req = 4'b1001;
        push(4'b1000, 8'hC3, 0);
        push(4'b0001, 8'h3C, 3);
        wait_done("wrap");

        // wdata/req change during LOAD is ignored
        wdata[1*8 +: 8] = 8'hBA;
        req = 4'b0010;
        push(4'b0010, 8'hBA, 0);
        @(negedge clk);
        chk("mid_ld", 32'(reg_ld), 32'd1);
        wdata[1*8 +: 8] = 8'h0B;
        req = 4'b0000;
        wait_done("midchange");
        chk("mid_reg_value", 32'(reg_q), 32'hBA);

        // reset during ACK: no grant, then ptr back to 0
        wdata[3*8 +: 8] = 8'h77;
        req = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        chk("ack_busy_pre", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("ack_rst_busy", 32'(busy), 32'd0);
        chk("ack_rst_gnt", 32'(gnt), 32'd0);
        req = 4'b0000;
        @(negedge clk);
        chk("ack_rst_gnt_next", 32'(gnt), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("ack_rst_gnt_after", 32'(gnt), 32'd0);
        wdata[1*8 +: 8] = 8'h11;
        wdata[3*8 +: 8] = 8'h33;
        req = 4'b1010;
        push(4'b0010, 8'h11, 0);
        push(4'b1000, 8'h33, 3);
        wait_done("post_reset");

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
